// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction tester: FSM state encodings and the
// default clock-rate timing constants reused by the debounce and timing blocks.
package reaction_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int                 CLK_HZ          = 125_000_000;
  localparam int                 TIMER_W         = 25;
  // 100 ms blink phases and a 10 ms debounce window at 125 MHz
  localparam logic [TIMER_W-1:0] BLINK_ON_CYCLES  = 25'd12_500_000;
  localparam logic [TIMER_W-1:0] BLINK_OFF_CYCLES = 25'd12_500_000;
  localparam logic [TIMER_W-1:0] DEBOUNCE_CYCLES  = 25'd1_250_000;

endpackage

// File: rtl/stimulus_driver_phase_timer.sv
// Phase timer: up-counter with synchronous clear and enable; expire flags the
// last cycle of a phase whose length is selected at runtime by limit.
module phase_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The owner clears on expire, so the count never reaches limit and never wraps
  assign expire = en && (count_q == (limit - ONE));

endmodule

// File: rtl/stimulus_driver.sv
// Blink sequencer: turns a one-cycle start request into blink_cnt ON/OFF
// pulses on o_drive, with busy while running and a done pulse at completion.
module stimulus_driver
  import reaction_pkg::*;
#(
  parameter int               CNT_W      = 25,
  parameter logic [CNT_W-1:0] ON_CYCLES  = 25'd12500000,
  parameter logic [CNT_W-1:0] OFF_CYCLES = 25'd12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] blink_cnt,
  input  logic       abort,
  output logic       o_drive,
  output logic       busy,
  output logic       done
);

  state_e           state_q, state_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             o_drive_q, o_drive_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_expire;
  logic [CNT_W-1:0] tmr_limit;

  assign tmr_en    = (state_q == ST_ON) || (state_q == ST_OFF);
  assign tmr_limit = (state_q == ST_ON) ? ON_CYCLES : OFF_CYCLES;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tmr_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (start && !abort) begin
          remaining_d = blink_cnt;
          state_d     = (blink_cnt != 4'd0) ? ST_ON : ST_FIN;
        end
      end
      ST_ON: begin
        if (abort) begin
          tmr_clear = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmr_expire) begin
          tmr_clear = 1'b1;
          // The last blink goes straight to FIN with no trailing OFF phase
          if (remaining_q > 4'd1) begin
            remaining_d = remaining_q - 4'd1;
            state_d     = ST_OFF;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_OFF: begin
        if (abort) begin
          tmr_clear = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmr_expire) begin
          tmr_clear = 1'b1;
          state_d   = ST_ON;
        end
      end
      ST_FIN: begin
        tmr_clear = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        tmr_clear = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it
    o_drive_d = (state_d == ST_ON);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= 4'd0;
      o_drive_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      o_drive_q   <= o_drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_drive = o_drive_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_stimulus_driver.sv
// Directed bench for stimulus_driver with ON=4 / OFF=3 cycle phases; expected
// per-cycle {o_drive,busy,done} patterns are hand-written bit masks (bit c = cycle c).
module tb_stimulus_driver;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] blink_cnt;
  logic       abort;
  logic       o_drive;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  stimulus_driver #(
    .CNT_W      (25),
    .ON_CYCLES  (25'd4),
    .OFF_CYCLES (25'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .blink_cnt (blink_cnt),
    .abort     (abort),
    .o_drive   (o_drive),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Start is driven in the current slot (cycle 0); each later cycle is checked
  // #1 after its clock edge, then that cycle's inputs are applied.
  task automatic run(input string name, input logic [3:0] cnt, input int len,
                     input logic [31:0] dv, input logic [31:0] bv, input logic [31:0] nv,
                     input int start2_cyc, input int abort_cyc, input int rst_cyc);
    logic [2:0] got;
    logic [2:0] exp;
    start     = 1'b1;
    blink_cnt = cnt;
    abort     = (abort_cyc == 0);
    for (int c = 1; c <= len; c++) begin
      @(posedge clk);
      #1;
      got = {o_drive, busy, done};
      exp = {dv[c], bv[c], nv[c]};
      check($sformatf("%s cyc%0d drv/busy/done", name, c), {29'd0, got}, {29'd0, exp});
      start     = 1'b0;
      abort     = 1'b0;
      rst_n     = 1'b1;
      blink_cnt = 4'hA;
      if (c == start2_cyc) begin
        start     = 1'b1;
        blink_cnt = 4'd5;
      end
      if (c == abort_cyc) abort = 1'b1;
      if (c == rst_cyc) rst_n = 1'b0;
    end
    $display("transaction %s cnt=%0d cycles=%0d checks=%0d passed=%0d",
             name, cnt, len, n_checks, n_pass);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b1;
    blink_cnt = 4'd3;
    abort     = 1'b0;

    // Reset holds everything low even while start is requested
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset cyc%0d drv/busy/done", i), {29'd0, o_drive, busy, done}, 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;

    run("t1_cnt1",      4'd1, 7,  32'h1E,    32'h3E,    32'h20,    -1, -1, -1);
    run("t2_cnt3",      4'd3, 21, 32'h78F1E, 32'hFFFFE, 32'h80000, -1, -1, -1);
    run("t3_cnt0",      4'd0, 3,  32'h0,     32'h2,     32'h2,     -1, -1, -1);
    run("t4_cnt2_ign",  4'd2, 13, 32'hF1E,   32'h1FFE,  32'h1000,   3, -1, -1);
    run("t4_restart",   4'd1, 7,  32'h1E,    32'h3E,    32'h20,    -1, -1, -1);
    run("t5_abort_off", 4'd3, 10, 32'h1E,    32'h7E,    32'h0,     -1,  6, -1);
    run("t5_idle_abort",4'd2, 4,  32'h0,     32'h0,     32'h0,     -1,  0, -1);
    run("t6_reset_on",  4'd3, 5,  32'h6,     32'h6,     32'h0,     -1, -1,  2);
    run("t6_fresh",     4'd2, 14, 32'hF1E,   32'h1FFE,  32'h1000,  -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
